// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, majority-vote bit decisions and a
// first-word fall-through receive FIFO carrying per-entry parity/framing flags.
module uart_rx_fifo #(
  parameter int CLK_DIV   = 54,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxd_i,
  output logic [7:0]         dout_o,
  output logic               perr_o,
  output logic               ferr_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               ovr_o,
  input  logic               ovr_clr_i,
  output logic [FIFO_AW:0]   count_o
);

  localparam int TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state;
  logic                   rx_meta, rxs, rxs_prev;
  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic                   start_edge;
  logic [3:0]             sub_cnt;
  logic [2:0]             bit_idx;
  logic                   stop_idx;
  logic [1:0]             samp;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr_q, ferr_q;
  logic                   maj, par_err, push;
  logic [EW-1:0]          push_word;

  logic [EW-1:0]          mem [DEPTH];
  logic [FIFO_AW:0]       wptr, rptr, count;
  logic                   full, pop, wr_en;
  logic [EW-1:0]          head;

  // rxs_prev trails the synchronized line so IDLE can spot a 1->0 transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd_i;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign start_edge = (state == IDLE) && rxs_prev && !rxs;
  assign tick       = (tick_cnt == TW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else if (start_edge || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  always_comb begin
    maj = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
    if (PARITY == 1)
      par_err = ~(^shreg ^ maj);
    else
      par_err = ^shreg ^ maj;
    push      = tick && (state == STOP) && (sub_cnt == 4'd9) &&
                (stop_idx == 1'(STOP_BITS - 1));
    push_word = {ferr_q | ~maj, perr_q, shreg};
  end

  // The last stop bit pushes at its vote point and drops straight to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sub_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      samp     <= 2'b11;
      shreg    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (start_edge) begin
        state   <= START;
        sub_cnt <= '0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
      end
    end else if (tick) begin
      sub_cnt <= sub_cnt + 1'b1;
      if (sub_cnt == 4'd7) samp[0] <= rxs;
      if (sub_cnt == 4'd8) samp[1] <= rxs;
      case (state)
        START: begin
          if (sub_cnt == 4'd9 && maj) begin
            state <= IDLE;
          end else if (sub_cnt == 4'd15) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (sub_cnt == 4'd9) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
          end else if (sub_cnt == 4'd15) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state    <= (PARITY != 0) ? PAR : STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PAR: begin
          if (sub_cnt == 4'd9) begin
            perr_q <= par_err;
          end else if (sub_cnt == 4'd15) begin
            state    <= STOP;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (sub_cnt == 4'd9) begin
            if (push) state <= IDLE;
            else      ferr_q <= ferr_q | ~maj;
          end else if (sub_cnt == 4'd15) begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Full is the count MSB since occupancy never exceeds DEPTH
  assign count   = wptr - rptr;
  assign full    = count[FIFO_AW];
  assign valid_o = (count != '0);
  assign pop     = valid_o && ready_i;
  assign wr_en   = push && (!full || pop);
  assign count_o = count;
  assign head    = mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[FIFO_AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      ovr_o <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (push && full && !pop)
        ovr_o <= 1'b1;
      else if (ovr_clr_i)
        ovr_o <= 1'b0;
    end
  end

  always_comb begin
    dout_o = '0;
    perr_o = 1'b0;
    ferr_o = 1'b0;
    if (valid_o) begin
      dout_o[DATA_BITS-1:0] = head[DATA_BITS-1:0];
      perr_o                = head[DATA_BITS];
      ferr_o                = head[DATA_BITS+1];
    end
  end

endmodule
